// File: rtl/vfd_capture_pkg.sv
`default_nettype none
// ============================================================================
// Package     : vfd_pkg
// Description : Shared types and constants for the VFD capture block:
//               FSM state encoding, default geometry and cell-index helper.
// Revision    : 1.0 - initial release
// ============================================================================
package vfd_pkg;

  localparam int VFD_GRID_W = 10;
  localparam int VFD_SEG_W  = 16;
  localparam int CELLS      = VFD_GRID_W * VFD_SEG_W;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    SCAN  = 2'd2
  } vfd_state_e;

  // Linear cell index: cells of one grid are contiguous.
  function automatic int cell_index(input int g, input int s, input int seg_w);
    return g * seg_w + s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vfd_capture_if.sv
`default_nettype none
// ============================================================================
// Interface   : vfd_capture_if
// Description : CPU-side strobes and renderer-side pixel read port.
//   grid_in/seg_in   : multiplexed strobes from the CPU ports
//   rd_grid/rd_seg   : pixel read address
//   rd_lit           : pixel lit, one cycle after the address
//   frame_strobe     : one-cycle pulse at end of a scan
//   busy             : clear or scan in progress
//   master = CPU/renderer side, slave = capture block
// Revision    : 1.0 - initial release
// ============================================================================
interface vfd_capture_if #(
  parameter int GRID_W = vfd_pkg::VFD_GRID_W,
  parameter int SEG_W  = vfd_pkg::VFD_SEG_W
);
  logic [GRID_W-1:0]         grid_in;
  logic [SEG_W-1:0]          seg_in;
  logic [$clog2(GRID_W)-1:0] rd_grid;
  logic [$clog2(SEG_W)-1:0]  rd_seg;
  logic                      rd_lit;
  logic                      frame_strobe;
  logic                      busy;

  modport master (
    output grid_in, seg_in, rd_grid, rd_seg,
    input  rd_lit, frame_strobe, busy
  );

  modport slave (
    input  grid_in, seg_in, rd_grid, rd_seg,
    output rd_lit, frame_strobe, busy
  );
endinterface
`default_nettype wire

// File: rtl/vfd_capture_settle.sv
`default_nettype none
// ============================================================================
// Module      : vfd_settle
// Description : Settle filter. The input vector is registered every cycle;
//               once it has been identical for SETTLE consecutive sample
//               comparisons it is copied to the stable output.
//   clk, reset : clock, synchronous active-high reset
//   sample_i   : raw input vector
//   stable_o   : last vector that stayed unchanged long enough
// Revision    : 1.0 - initial release
// ============================================================================
module vfd_settle #(
  parameter int WIDTH  = 26,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sample_i,
  output logic [WIDTH-1:0] stable_o
);

  localparam int SC_W = $clog2(SETTLE + 1);

  logic [WIDTH-1:0] sample_q;
  logic [SC_W-1:0]  stab_cnt_q, stab_cnt_d;
  logic [WIDTH-1:0] stable_q, stable_d;

  always_comb begin
    stab_cnt_d = '0;
    stable_d   = stable_q;
    if (sample_i == sample_q) begin
      if (stab_cnt_q != SC_W'(SETTLE)) stab_cnt_d = stab_cnt_q + 1'b1;
      else                             stab_cnt_d = stab_cnt_q;
    end
    // Reloading while saturated rewrites the same value, so no edge detect.
    if (stab_cnt_d == SC_W'(SETTLE)) stable_d = sample_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q   <= '0;
      stab_cnt_q <= '0;
      stable_q   <= '0;
    end else begin
      sample_q   <= sample_i;
      stab_cnt_q <= stab_cnt_d;
      stable_q   <= stable_d;
    end
  end

  assign stable_o = stable_q;

endmodule
`default_nettype wire

// File: rtl/vfd_capture.sv
`default_nettype none
// ============================================================================
// Module      : vfd_capture
// Description : Rebuilds a persistence-filtered VFD frame image from the
//               multiplexed grid/segment strobes. Every TICK_DIV cycles the
//               settled strobes are snapshotted and all cells are swept:
//               lit cells load DECAY, unlit cells count down to 0.
//   clk, reset : clock, synchronous active-high reset
//   bus        : vfd_capture_if.slave (strobes in, pixel read port out)
// Revision    : 1.0 - initial release
// ============================================================================
module vfd_capture
  import vfd_pkg::*;
#(
  parameter int GRID_W   = VFD_GRID_W,
  parameter int SEG_W    = VFD_SEG_W,
  parameter int CNT_W    = 4,
  parameter int DECAY    = 3,
  parameter int TICK_DIV = 1024,
  parameter int SETTLE   = 2
) (
  input  logic          clk,
  input  logic          reset,
  vfd_capture_if.slave  bus
);

  localparam int NCELLS = GRID_W * SEG_W;
  localparam int IDX_W  = $clog2(NCELLS);
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int RG_W   = $clog2(GRID_W);
  localparam int RS_W   = $clog2(SEG_W);

  // ---------------- sample tick ----------------
  logic [TICK_W-1:0] tick_cnt_q;
  logic              tick;

  assign tick = (tick_cnt_q == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset)     tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= '0;
    else           tick_cnt_q <= tick_cnt_q + 1'b1;
  end

  // ---------------- settle filter ----------------
  logic [GRID_W-1:0] stable_grid;
  logic [SEG_W-1:0]  stable_seg;

  vfd_settle #(
    .WIDTH  (GRID_W + SEG_W),
    .SETTLE (SETTLE)
  ) u_settle (
    .clk      (clk),
    .reset    (reset),
    .sample_i ({bus.grid_in, bus.seg_in}),
    .stable_o ({stable_grid, stable_seg})
  );

  // ---------------- cell memory ----------------
  logic [CNT_W-1:0] mem_q [NCELLS];
  logic             mem_we;
  logic [IDX_W-1:0] mem_waddr;
  logic [CNT_W-1:0] mem_wdata;

  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem_q[mem_waddr] <= mem_wdata;
  end

  // ---------------- sweep FSM ----------------
  vfd_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [RG_W-1:0]   g_q, g_d;   // grid/segment of idx, tracked to avoid a divider
  logic [RS_W-1:0]   s_q, s_d;
  logic [GRID_W-1:0] snap_grid_q, snap_grid_d;
  logic [SEG_W-1:0]  snap_seg_q, snap_seg_d;
  logic              frame_strobe_q, frame_strobe_d;
  logic [CNT_W-1:0]  cur_cnt;
  logic              cell_on;

  assign cur_cnt = mem_q[idx_q];
  assign cell_on = snap_grid_q[g_q] & snap_seg_q[s_q];

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    g_d            = g_q;
    s_d            = s_q;
    snap_grid_d    = snap_grid_q;
    snap_seg_d     = snap_seg_q;
    frame_strobe_d = 1'b0;
    mem_we         = 1'b0;
    mem_waddr      = idx_q;
    mem_wdata      = '0;
    case (state_q)
      CLEAR: begin
        mem_we = 1'b1;
        if (idx_q == IDX_W'(NCELLS - 1)) begin
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      IDLE: begin
        if (tick) begin
          snap_grid_d = stable_grid;
          snap_seg_d  = stable_seg;
          idx_d       = '0;
          g_d         = '0;
          s_d         = '0;
          state_d     = SCAN;
        end
      end
      SCAN: begin
        mem_we = 1'b1;
        if (cell_on)              mem_wdata = CNT_W'(DECAY);
        else if (cur_cnt != '0)   mem_wdata = cur_cnt - 1'b1;
        else                      mem_wdata = '0;
        if (idx_q == IDX_W'(NCELLS - 1)) begin
          idx_d          = '0;
          state_d        = IDLE;
          frame_strobe_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
          if (s_q == RS_W'(SEG_W - 1)) begin
            s_d = '0;
            g_d = g_q + 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= CLEAR;
      idx_q          <= '0;
      g_q            <= '0;
      s_q            <= '0;
      snap_grid_q    <= '0;
      snap_seg_q     <= '0;
      frame_strobe_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      g_q            <= g_d;
      s_q            <= s_d;
      snap_grid_q    <= snap_grid_d;
      snap_seg_q     <= snap_seg_d;
      frame_strobe_q <= frame_strobe_d;
    end
  end

  // ---------------- pixel read port ----------------
  logic             rd_in_range;
  logic [IDX_W-1:0] rd_addr;
  logic             rd_lit_q;

  assign rd_in_range = (int'(bus.rd_grid) < GRID_W) && (int'(bus.rd_seg) < SEG_W);
  // Out-of-range addresses are steered to cell 0 so the array is never
  // indexed past its end; the result is masked below anyway.
  assign rd_addr = rd_in_range
                 ? IDX_W'(cell_index(int'(bus.rd_grid), int'(bus.rd_seg), SEG_W))
                 : '0;

  always_ff @(posedge clk) begin
    if (reset) rd_lit_q <= 1'b0;
    else       rd_lit_q <= rd_in_range && (state_q != CLEAR) && (mem_q[rd_addr] != '0);
  end

  assign bus.rd_lit       = rd_lit_q;
  assign bus.frame_strobe = frame_strobe_q;
  assign bus.busy         = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_vfd_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_vfd_capture
// Description : Directed self-checking bench for vfd_capture (default
//               geometry 10x16, DECAY=3, TICK_DIV=1024, SETTLE=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vfd_capture;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  vfd_capture_if #(.GRID_W(10), .SEG_W(16)) bus ();

  vfd_capture #(
    .GRID_W   (10),
    .SEG_W    (16),
    .CNT_W    (4),
    .DECAY    (3),
    .TICK_DIV (1024),
    .SETTLE   (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, required finish before 3000000");
    $fatal(1);
  end

  // Present an address on a falling edge, return rd_lit one cycle later.
  task automatic read_cell(input int g, input int s, output logic lit);
    @(negedge clk);
    bus.rd_grid = 4'(g);
    bus.rd_seg  = 4'(s);
    @(negedge clk);
    lit = bus.rd_lit;
  endtask

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.frame_strobe === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Called on the falling edge where reset was just released.
  task automatic measure_clear(output int n, output int strobes, output int lit_seen);
    n = 0; strobes = 0; lit_seen = 0;
    while (bus.busy === 1'b1 && n < 400) begin
      n++;
      if (bus.frame_strobe !== 1'b0) strobes++;
      if (bus.rd_lit !== 1'b0) lit_seen++;
      bus.rd_grid = 4'(n % 10);
      bus.rd_seg  = 4'(n % 16);
      @(negedge clk);
    end
  endtask

  task automatic count_lit_cells(output int lit_cnt);
    logic lit;
    lit_cnt = 0;
    for (int g = 0; g < 10; g++)
      for (int s = 0; s < 16; s++) begin
        read_cell(g, s, lit);
        if (lit !== 1'b0) lit_cnt++;
      end
  endtask

  task automatic test_reset;
    int n, strobes, lit_seen, lit_cnt;
    logic lit;
    bus.grid_in = '0; bus.seg_in = '0; bus.rd_grid = '0; bus.rd_seg = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", bus.busy); end
    checks++; if (bus.rd_lit !== 1'b0) begin errors++; $display("FAIL reset_rd_lit: got %b expected 0", bus.rd_lit); end
    checks++; if (bus.frame_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b expected 0", bus.frame_strobe); end
    reset = 1'b0;
    measure_clear(n, strobes, lit_seen);
    checks++; if (n !== 160) begin errors++; $display("FAIL clear_busy_cycles: got %0d expected 160", n); end
    checks++; if (strobes !== 0) begin errors++; $display("FAIL clear_strobes: got %0d expected 0", strobes); end
    checks++; if (lit_seen !== 0) begin errors++; $display("FAIL clear_rd_lit: got %0d expected 0", lit_seen); end
    count_lit_cells(lit_cnt);
    checks++; if (lit_cnt !== 0) begin errors++; $display("FAIL clear_all_dark: got %0d lit expected 0", lit_cnt); end
  endtask

  task automatic test_single_cell;
    bit ok;
    logic lit;
    bus.grid_in = 10'h001; bus.seg_in = 16'h0001;
    wait_frame(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_frame: got %b expected 1", ok); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_at_strobe: got %b expected 0", bus.busy); end
    @(negedge clk);
    checks++; if (bus.frame_strobe !== 1'b0) begin errors++; $display("FAIL strobe_width: got %b expected 0", bus.frame_strobe); end
    read_cell(0, 0, lit);
    checks++; if (lit !== 1'b1) begin errors++; $display("FAIL single_0_0: got %b expected 1", lit); end
    read_cell(0, 1, lit);
    checks++; if (lit !== 1'b0) begin errors++; $display("FAIL single_0_1: got %b expected 0", lit); end
    read_cell(1, 0, lit);
    checks++; if (lit !== 1'b0) begin errors++; $display("FAIL single_1_0: got %b expected 0", lit); end
  endtask

  task automatic test_decay;
    bit ok;
    logic lit;
    logic exp;
    bus.grid_in = 10'h000;
    for (int k = 1; k <= 3; k++) begin
      wait_frame(ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL decay_frame%0d: got %b expected 1", k, ok); end
      read_cell(0, 0, lit);
      exp = (k < 3) ? 1'b1 : 1'b0;
      checks++; if (lit !== exp) begin errors++; $display("FAIL decay_scan%0d: got %b expected %b", k, lit, exp); end
    end
  endtask

  task automatic test_glitch;
    bit ok;
    logic lit;
    bus.grid_in = 10'h001; bus.seg_in = 16'h0002;
    wait_frame(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL glitch_frame_a: got %b expected 1", ok); end
    // Next tick edge is 864 rising edges after this strobe; glitch the
    // segment lines for just the cycle ending at that edge.
    repeat (863) @(negedge clk);
    bus.seg_in = 16'h8000;
    @(negedge clk);
    bus.seg_in = 16'h0002;
    wait_frame(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL glitch_frame_b: got %b expected 1", ok); end
    read_cell(0, 15, lit);
    checks++; if (lit !== 1'b0) begin errors++; $display("FAIL glitch_0_15: got %b expected 0", lit); end
    read_cell(0, 1, lit);
    checks++; if (lit !== 1'b1) begin errors++; $display("FAIL glitch_0_1: got %b expected 1", lit); end
  endtask

  task automatic test_reset_mid_scan;
    bit ok;
    int n, strobes, lit_seen, lit_cnt;
    wait_frame(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL midscan_frame: got %b expected 1", ok); end
    // 864 edges to the tick, then 50 more to sit at idx 50.
    repeat (914) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midscan_in_scan: got %b expected 1", bus.busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    measure_clear(n, strobes, lit_seen);
    checks++; if (n !== 160) begin errors++; $display("FAIL midscan_busy_cycles: got %0d expected 160", n); end
    checks++; if (strobes !== 0) begin errors++; $display("FAIL midscan_strobes: got %0d expected 0", strobes); end
    checks++; if (lit_seen !== 0) begin errors++; $display("FAIL midscan_rd_lit: got %0d expected 0", lit_seen); end
    count_lit_cells(lit_cnt);
    checks++; if (lit_cnt !== 0) begin errors++; $display("FAIL midscan_all_dark: got %0d lit expected 0", lit_cnt); end
  endtask

  task automatic test_full_oob;
    bit ok;
    logic lit;
    bus.grid_in = '1; bus.seg_in = '1;
    wait_frame(ok);
    wait_frame(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL full_frame: got %b expected 1", ok); end
    read_cell(12, 3, lit);
    checks++; if (lit !== 1'b0) begin errors++; $display("FAIL oob_12_3: got %b expected 0", lit); end
    read_cell(9, 15, lit);
    checks++; if (lit !== 1'b1) begin errors++; $display("FAIL full_9_15: got %b expected 1", lit); end
    read_cell(0, 0, lit);
    checks++; if (lit !== 1'b1) begin errors++; $display("FAIL full_0_0: got %b expected 1", lit); end
    read_cell(5, 7, lit);
    checks++; if (lit !== 1'b1) begin errors++; $display("FAIL full_5_7: got %b expected 1", lit); end
    read_cell(10, 0, lit);
    checks++; if (lit !== 1'b0) begin errors++; $display("FAIL oob_10_0: got %b expected 0", lit); end
    read_cell(15, 15, lit);
    checks++; if (lit !== 1'b0) begin errors++; $display("FAIL oob_15_15: got %b expected 0", lit); end
  endtask

  initial begin
    test_reset();
    test_single_cell();
    test_decay();
    test_glitch();
    test_reset_mid_scan();
    test_full_oob();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vfd_capture.md
# vfd_capture

Display-side endpoint for the microcontroller's output ports. It takes the multiplexed grid and segment strobes that the CPU core drives through ports C–I and rebuilds a stable, persistence-filtered frame image. The video generator reads that image through a random-access pixel port. It sits between the CPU core and the scan-out/renderer, and emulates VFD phosphor afterglow so that multiplexing flicker and nibble-wise port updates do not reach the screen.

## Interface
- GRID_W, 10: number of grid strobes.
- SEG_W, 16: number of segment lines.
- CNT_W, 4: persistence counter width per cell.
- DECAY, 3: counter load value when a cell is lit; range 1..2^CNT_W-1.
- TICK_DIV, 1024: clk cycles per sample tick; must be ≥ GRID_W*SEG_W+2.
- SETTLE, 2: consecutive identical clk samples before the inputs are accepted as stable.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- grid_in  in  GRID_W  grid strobes, active-high, synchronous to clk, assembled at top level from CPU port bits.
- seg_in  in  SEG_W  segment lines, active-high, synchronous to clk.
- rd_grid  in  ceil(log2 GRID_W)  read address, grid.
- rd_seg  in  ceil(log2 SEG_W)  read address, segment.
- rd_lit  out  1  cell lit, one cycle after the address is presented.
- frame_strobe  out  1  one-cycle pulse when a scan completes.
- busy  out  1  high during CLEAR or SCAN.

## Operation
- Divider: tick_cnt runs 0..TICK_DIV-1 and wraps. tick is asserted when tick_cnt = TICK_DIV-1.
- Settle filter:
  - Register {grid_in, seg_in} each clk.
  - stab_cnt increments, saturating at SETTLE, while the sample equals the previous sample. Any difference resets stab_cnt to 0.
  - The stable_grid/stable_seg registers load the sample in the cycle stab_cnt reaches SETTLE.
  - Transients shorter than SETTLE+1 cycles are never captured.
- Cell memory: GRID_W*SEG_W counters of CNT_W bits. Cell index = g*SEG_W+s.
- FSM states:
  - CLEAR: entered from reset. Writes 0 to one cell per clk, index 0 upward. Goes to IDLE after the last cell.
  - IDLE: on tick, copy stable_grid/stable_seg into snap_grid/snap_seg, set idx=0, go to SCAN.
  - SCAN: one cell per clk. If snap_grid[g]&snap_seg[s], load cnt with DECAY. Otherwise cnt becomes cnt-1, saturating at 0. After the last cell, go to IDLE and pulse frame_strobe.
- A tick arriving in CLEAR or SCAN is dropped. Nothing is queued.
- Read port: rd_lit <= (cnt[rd_grid*SEG_W+rd_seg] != 0) is registered.
  - rd_lit is forced to 0 for out-of-range addresses.
  - rd_lit is forced to 0 while in CLEAR.
- During SCAN, a read of a cell returns its pre-update or post-update value depending on idx; both are legal. Reads never stall.

## Timing
- Reset values: FSM=CLEAR, tick_cnt=0, stab_cnt=0, stable/snap registers=0, idx=0, rd_lit=0, frame_strobe=0, busy=1.
- CLEAR lasts GRID_W*SEG_W cycles after reset deasserts. busy falls in the following cycle.
- SCAN starts the cycle after tick and lasts GRID_W*SEG_W cycles. frame_strobe is high in the cycle after the last cell is written. busy falls in that same cycle.
- Read latency is 1 clk. The address is sampled every cycle.
- A lit cell stays visible for DECAY sample ticks after its last lit scan. It goes dark on the DECAY-th unlit scan.
- Input-to-screen latency is at most SETTLE+1+TICK_DIV+GRID_W*SEG_W cycles.
- Reset asserted mid-SCAN or mid-CLEAR aborts the sweep, restarts CLEAR at idx 0, and suppresses frame_strobe.
- Simultaneous input change and tick: snap takes the previous stable values.

## Structure
- Shared package vfd_pkg:
  - FSM state enum {CLEAR, IDLE, SCAN}.
  - cell-index helper function.
  - localparam CELLS = GRID_W*SEG_W.
- One sub-module, vfd_settle: sample register, stab_cnt, and the stable output registers, parameterised by width and SETTLE.
- Cell memory is an inferred array with a write port (scan/clear) and two read ports (scan RMW and rd port). It is distributed RAM; no sync-read BRAM.

## Test plan
- Reset release: busy=1 for exactly 160 cycles (defaults); rd_lit=0 for every address; frame_strobe never pulses during CLEAR.
- Hold grid_in=10'h001, seg_in=16'h0001 → after the next frame_strobe, rd (0,0) → rd_lit=1 one cycle later; rd (0,1) and (1,0) → 0.
- Then drive grid_in=0 → (0,0) reads 1 after unlit scans 1 and 2, and 0 after scan 3 (DECAY=3).
- Stable seg_in=16'h0002 with a 1-clk glitch to 16'h8000 just before a tick, grid_in=10'h001 → (0,15) never lit; (0,1) lit.
- Assert reset for 1 cycle at SCAN idx 50 → no frame_strobe; busy high for 160 cycles; all cells read 0 afterwards.
- rd_grid=12, rd_seg=3 while a full frame is lit (all inputs 1) → rd_lit=0; rd_grid=9, rd_seg=15 → 1.
